// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared types and helpers for the vote countdown panel
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Active-low segments, bit order gfedcba; non-decimal nibbles blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // One BCD digit of a decrement: returns {borrow_out, new_digit}.
    function automatic logic [4:0] bcd_dec_digit(input logic [3:0] d, input logic borrow_in);
        if (!borrow_in)
            return {1'b0, d};
        else if (d == 4'd0)
            return {1'b1, 4'd9};
        else
            return {1'b0, d - 4'd1};
    endfunction

    // Binary to four-digit BCD, for elaborating the start value.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - clock-enable pulse generator, one tick every DIV cycles
// Ports: clk, rst (async, active-high), clr (sync restart from zero), tick (1-cycle pulse)
module tick_gen
    import vote_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int             W    = width_of(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/vote_countdown.sv
// rtl/vote_countdown.sv - majority-vote lock controller with BCD countdown and 7-seg display
// Ports: clk, rst (async, active-high), btn_n[N_BTN] raw active-low buttons, clear (sync re-arm),
//        led status, seg[7*DIGITS] active-low gfedcba per digit (digit 0 = units),
//        votes[N_BTN] latched votes, expired (locked)
module vote_countdown
    import vote_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int N_BTN       = 3,
    parameter int THRESH      = 2,
    parameter int DIGITS      = 2,
    parameter int COUNT_START = 9,
    parameter int BLINK_HZ    = 5,
    parameter int DEB_CYC     = 500_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BTN-1:0]    btn_n,
    input  logic                clear,
    output logic                led,
    output logic [7*DIGITS-1:0] seg,
    output logic [N_BTN-1:0]    votes,
    output logic                expired
);

    localparam int              CW        = 4 * DIGITS;
    localparam int              SW        = 7 * DIGITS;
    localparam logic [15:0]     START16   = to_bcd(COUNT_START);
    localparam logic [CW-1:0]   START_BCD = START16[CW-1:0];
    localparam int              DW        = width_of(DEB_CYC + 2);
    localparam logic [DW-1:0]   DEB_HIT   = DW'(DEB_CYC);
    localparam logic [DW-1:0]   DEB_SAT   = DW'(DEB_CYC + 1);
    localparam int              HALF_RAW  = CLK_HZ / (2 * BLINK_HZ);
    localparam int              HALF      = (HALF_RAW > 0) ? HALF_RAW : 1;

    function automatic logic [SW-1:0] decode_all(input logic [CW-1:0] c);
        logic [SW-1:0] s;
        s = '0;
        for (int k = 0; k < DIGITS; k++)
            s[7*k +: 7] = seg7(c[4*k +: 4]);
        return s;
    endfunction

    localparam logic [SW-1:0] SEG_RESET = decode_all(START_BCD);

    state_t           state, state_next;
    logic [CW-1:0]    count, count_next, count_dec;
    logic [N_BTN-1:0] accept, votes_next;
    logic             phase, phase_next, led_next;
    logic             sec_tick, blink_tick, sec_clr;
    logic             borrow;
    logic [4:0]       step;

    // Debounce: the low-sample counter saturates one past the threshold, so
    // accept is a single-cycle pulse per press and a held button cannot
    // re-latch after clear.
    for (genvar i = 0; i < N_BTN; i++) begin : g_deb
        logic          sync1, sync2;
        logic [DW-1:0] low_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1   <= 1'b1;
                sync2   <= 1'b1;
                low_cnt <= '0;
            end else begin
                sync1 <= btn_n[i];
                sync2 <= sync1;
                if (sync2)
                    low_cnt <= '0;
                else if (low_cnt != DEB_SAT)
                    low_cnt <= low_cnt + DW'(1);
            end
        end

        assign accept[i] = (low_cnt == DEB_HIT);
    end

    // The second counter only runs while counting down.
    assign sec_clr = clear || (state != RUN);

    tick_gen #(.DIV(CLK_HZ)) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (sec_clr),
        .tick (sec_tick)
    );

    tick_gen #(.DIV(HALF)) u_blink_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .tick (blink_tick)
    );

    always_comb begin
        count_dec = count;
        borrow    = 1'b1;
        step      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            step               = bcd_dec_digit(count[4*k +: 4], borrow);
            count_dec[4*k +: 4] = step[3:0];
            borrow             = step[4];
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        votes_next = votes | (accept & {N_BTN{state != EXPIRED}});
        phase_next = blink_tick ? ~phase : phase;

        case (state)
            IDLE: begin
                count_next = START_BCD;
                if (|votes)
                    state_next = RUN;
            end
            RUN: begin
                if (sec_tick) begin
                    count_next = count_dec;
                    if (count_dec == '0)
                        state_next = EXPIRED;
                end
            end
            EXPIRED: count_next = '0;
            default: state_next = IDLE;
        endcase

        if (clear) begin
            votes_next = '0;
            count_next = START_BCD;
            phase_next = 1'b0;
            state_next = IDLE;
        end

        // Outputs are registered from next-state values so they line up with count.
        led_next = 1'b1;
        if (state_next == EXPIRED)
            led_next = 1'b0;
        else if (state_next == RUN && $countones(votes_next) >= THRESH)
            led_next = phase_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= START_BCD;
            votes   <= '0;
            phase   <= 1'b0;
            led     <= 1'b0;
            seg     <= SEG_RESET;
            expired <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            votes   <= votes_next;
            phase   <= phase_next;
            led     <= led_next;
            seg     <= decode_all(count_next);
            expired <= (state_next == EXPIRED);
        end
    end

endmodule

// File: tb/tb_vote_countdown.sv
// tb/tb_vote_countdown.sv - self-checking bench for vote_countdown
module tb_vote_countdown;

    localparam int CLK_HZ      = 20;
    localparam int N_BTN       = 3;
    localparam int THRESH      = 2;
    localparam int DIGITS      = 2;
    localparam int COUNT_START = 12;
    localparam int BLINK_HZ    = 2;
    localparam int DEB_CYC     = 3;
    localparam int HALF        = CLK_HZ / (2 * BLINK_HZ);

    localparam logic [13:0] SEG12 = 14'b1111001_0100100;
    localparam logic [13:0] SEG11 = 14'b1111001_1111001;
    localparam logic [13:0] SEG07 = 14'b1000000_1111000;
    localparam logic [13:0] SEG00 = 14'b1000000_1000000;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        clear = 1'b0;
    logic [2:0]  btn_n = 3'b111;
    logic        led;
    logic [13:0] seg;
    logic [2:0]  votes;
    logic        expired;

    vote_countdown #(
        .CLK_HZ      (CLK_HZ),
        .N_BTN       (N_BTN),
        .THRESH      (THRESH),
        .DIGITS      (DIGITS),
        .COUNT_START (COUNT_START),
        .BLINK_HZ    (BLINK_HZ),
        .DEB_CYC     (DEB_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_n   (btn_n),
        .clear   (clear),
        .led     (led),
        .seg     (seg),
        .votes   (votes),
        .expired (expired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] seg_of(input int v);
        return {dec7(v / 10), dec7(v % 10)};
    endfunction

    // Behavioural model: state as 0 idle / 1 counting / 2 locked, count as a
    // plain integer, timing from cycle counters, presses from low run-lengths.
    int          m_state, m_count, m_run_cyc, m_blink_cyc;
    logic        m_phase;
    logic [2:0]  m_votes;
    int          run_len [3][4];   // [btn][age]: low-sample run length, age in cycles
    logic        m_led;
    logic [13:0] m_seg;
    logic        m_exp;
    logic        chk_en = 1'b0;

    task automatic model_reset();
        m_state     = 0;
        m_count     = COUNT_START;
        m_run_cyc   = 0;
        m_blink_cyc = 0;
        m_phase     = 1'b0;
        m_votes     = '0;
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < 4; a++)
                run_len[i][a] = 0;
        m_led = 1'b0;
        m_seg = seg_of(COUNT_START);
        m_exp = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] acc;
        int         old_state;
        logic [2:0] old_votes;
        acc = '0;
        // A press counts once the raw line has been low DEB_CYC samples,
        // seen through two sync stages plus the latch stage.
        for (int i = 0; i < 3; i++) begin
            for (int a = 3; a > 0; a--)
                run_len[i][a] = run_len[i][a-1];
            run_len[i][0] = btn_n[i] ? 0 : ((run_len[i][1] < 255) ? run_len[i][1] + 1 : 255);
            acc[i] = (run_len[i][3] == DEB_CYC);
        end
        if (clear) begin
            m_votes     = '0;
            m_state     = 0;
            m_count     = COUNT_START;
            m_run_cyc   = 0;
            m_blink_cyc = 0;
            m_phase     = 1'b0;
        end else begin
            m_blink_cyc++;
            if (m_blink_cyc % HALF == 0)
                m_phase = ~m_phase;
            old_state = m_state;
            old_votes = m_votes;
            if (old_state != 2)
                m_votes = m_votes | acc;
            if (old_state == 0 && old_votes != 0) begin
                m_state   = 1;
                m_run_cyc = 0;
            end else if (old_state == 1) begin
                m_run_cyc++;
                if (m_run_cyc % CLK_HZ == 0) begin
                    m_count--;
                    if (m_count == 0)
                        m_state = 2;
                end
            end
        end
        m_exp = (m_state == 2);
        m_seg = seg_of(m_count);
        if (m_state == 2)
            m_led = 1'b0;
        else if (m_state == 1 && $countones(m_votes) >= THRESH)
            m_led = m_phase;
        else
            m_led = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst)
            model_reset();
        else
            model_step();
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("led_vs_model", led, m_led);
            check("seg_vs_model", seg, m_seg);
            check("votes_vs_model", votes, m_votes);
            check("expired_vs_model", expired, m_exp);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        model_reset();
        cyc(2);
        check("reset_led", led, 1'b0);
        check("reset_seg", seg, SEG12);
        check("reset_votes", votes, 3'b000);
        check("reset_expired", expired, 1'b0);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        cyc(100);
        check("idle_seg", seg, SEG12);
        check("idle_led", led, 1'b1);
        check("idle_votes", votes, 3'b000);
        check("idle_expired", expired, 1'b0);
        check("model_idle_led", m_led, 1'b1);

        // Short glitch must not vote.
        btn_n[0] = 1'b0;
        cyc(2);
        btn_n[0] = 1'b1;
        cyc(10);
        check("short_press", votes, 3'b000);

        // Press latency 2 + DEB_CYC + 1.
        btn_n[0] = 1'b0;
        cyc(5);
        check("press_latency_early", votes, 3'b000);
        cyc(1);
        check("press_latency", votes, 3'b001);
        check("model_press", m_votes, 3'b001);
        btn_n[0] = 1'b1;
        cyc(1);
        cyc(19);
        check("first_tick_early", seg, SEG12);
        cyc(1);
        check("first_tick", seg, SEG11);

        btn_n[1] = 1'b0;
        cyc(6);
        btn_n[1] = 1'b1;
        check("two_votes", votes, 3'b011);

        for (int i = 0; i < 400 && !expired; i++)
            cyc(1);
        check("expire_reached", expired, 1'b1);
        check("expire_seg", seg, SEG00);
        check("expire_led", led, 1'b0);

        btn_n[2] = 1'b0;
        cyc(8);
        btn_n[2] = 1'b1;
        cyc(2);
        check("expired_frozen", votes, 3'b011);

        // clear together with an accepted press.
        btn_n[2] = 1'b0;
        cyc(5);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("clear_votes", votes, 3'b000);
        check("clear_seg", seg, SEG12);
        check("clear_led", led, 1'b1);
        check("clear_expired", expired, 1'b0);
        cyc(10);
        check("held_no_relatch", votes, 3'b000);
        btn_n[2] = 1'b1;
        cyc(3);

        btn_n[0] = 1'b0;
        cyc(5);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        btn_n[0] = 1'b1;
        check("clear_wins_idle", votes, 3'b000);
        cyc(3);

        // Simultaneous presses both latch.
        btn_n = 3'b010;
        cyc(6);
        btn_n = 3'b111;
        check("simultaneous", votes, 3'b101);

        for (int i = 0; i < 400 && seg != SEG07; i++)
            cyc(1);
        check("reach_07", seg, SEG07);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_led", led, 1'b0);
        check("midrun_rst_seg", seg, SEG12);
        check("midrun_rst_votes", votes, 3'b000);
        check("midrun_rst_expired", expired, 1'b0);
        cyc(2);
        #2 rst = 1'b0;
        cyc(1);
        check("after_rst_seg", seg, SEG12);
        check("after_rst_led", led, 1'b1);

        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                if ($urandom_range(7) == 0)
                    btn_n[i] = ~btn_n[i];
            clear = ($urandom_range(299) == 0);
        end
        clear = 1'b0;
        btn_n = 3'b111;
        cyc(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
